// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit: sizes, fetches and presents 1-3 byte instructions.
// Optional illegal-opcode trap: define ILLEGAL_OPCODE_TRAP_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        opcode,
  output logic [15:0]       operand,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH_OP = 3'd0,
    S_FETCH_LO = 3'd1,
    S_FETCH_HI = 3'd2,
    S_PRESENT  = 3'd3
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    S_HALT     = 3'd4
`endif
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_rd;
  logic              r_valid;
  logic [7:0]        r_opcode;
  logic [15:0]       r_operand;
  logic [1:0]        r_len;
  logic [ADDR_W-1:0] r_instr_pc;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic              r_illegal;
`endif

  logic [1:0] w_len;
  logic       w_xfer;

  always_comb begin
    w_len = 2'd1;
    case (mem_rdata)
      8'hA9, 8'h01: w_len = 2'd2;
      8'h4C, 8'h8D: w_len = 2'd3;
      default:      w_len = 2'd1;
    endcase
  end

  assign w_xfer = r_mem_rd & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH_OP;
      r_pc       <= RESET_VECTOR;
      r_mem_rd   <= 1'b0;
      r_valid    <= 1'b0;
      r_opcode   <= 8'h00;
      r_operand  <= 16'h0000;
      r_len      <= 2'd0;
      r_instr_pc <= {ADDR_W{1'b0}};
`ifdef ILLEGAL_OPCODE_TRAP_EN
      r_illegal  <= 1'b0;
`endif
    end else if (redirect_en) begin
      // Redirect overrides any coincident byte transfer or handshake.
      r_pc     <= redirect_addr;
      r_state  <= S_FETCH_OP;
      r_mem_rd <= 1'b1;
      r_valid  <= 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH_OP: begin
          if (!r_mem_rd) begin
            r_mem_rd <= 1'b1;
          end else if (mem_ack) begin
            r_opcode   <= mem_rdata;
            r_instr_pc <= r_pc;
            r_operand  <= 16'h0000;
            r_len      <= w_len;
            r_pc       <= r_pc + ADDR_W'(1);
            if (w_len != 2'd1) begin
              r_state <= S_FETCH_LO;
            end else begin
              r_state  <= S_PRESENT;
              r_mem_rd <= 1'b0;
              r_valid  <= 1'b1;
`ifdef ILLEGAL_OPCODE_TRAP_EN
              // Every listed opcode is multi-byte, so a 1-byte size means unknown.
              r_illegal <= 1'b1;
`endif
            end
          end
        end
        S_FETCH_LO: begin
          if (w_xfer) begin
            r_operand[7:0] <= mem_rdata;
            r_pc           <= r_pc + ADDR_W'(1);
            if (r_len == 2'd3) begin
              r_state <= S_FETCH_HI;
            end else begin
              r_state  <= S_PRESENT;
              r_mem_rd <= 1'b0;
              r_valid  <= 1'b1;
            end
          end
        end
        S_FETCH_HI: begin
          if (w_xfer) begin
            r_operand[15:8] <= mem_rdata;
            r_pc            <= r_pc + ADDR_W'(1);
            r_state         <= S_PRESENT;
            r_mem_rd        <= 1'b0;
            r_valid         <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            if (r_illegal) begin
              r_state  <= S_HALT;
              r_mem_rd <= 1'b0;
            end else begin
              r_state  <= S_FETCH_OP;
              r_mem_rd <= 1'b1;
            end
`else
            r_state  <= S_FETCH_OP;
            r_mem_rd <= 1'b1;
`endif
          end
        end
`ifdef ILLEGAL_OPCODE_TRAP_EN
        S_HALT: begin
          r_mem_rd <= 1'b0;
          r_valid  <= 1'b0;
        end
`endif
        default: begin
          r_state  <= S_FETCH_OP;
          r_mem_rd <= 1'b0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr    = r_pc;
  assign mem_rd      = r_mem_rd;
  assign instr_valid = r_valid;
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign instr_len   = r_len;
  assign instr_pc    = r_instr_pc;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign illegal_op  = r_illegal;
`else
  assign illegal_op  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: memory responder plus scoreboard of expected instructions.
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        redirect_en;
  logic [15:0] redirect_addr;
  logic        illegal_op;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .operand      (operand),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [1:0]  len;
    logic [15:0] pc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [0:65535];
  int         total = 0;
  int         bad = 0;
  int         ack_delay = 0;
  bit         ack_en = 1'b0;
  bit         ack_always = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [15:0] opnd,
                      input logic [1:0] len, input logic [15:0] pc);
    exp_t e;
    e.op = op; e.opnd = opnd; e.len = len; e.pc = pc;
    sb.push_back(e);
  endtask

  // Waits (bounded) for instr_valid, then pops and checks the oldest expectation.
  task automatic expect_instr(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (instr_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (instr_valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_opcode"},  32'(opcode),    32'(e.op));
      chk({tag, "_operand"}, 32'(operand),   32'(e.opnd));
      chk({tag, "_len"},     32'(instr_len), 32'(e.len));
      chk({tag, "_pc"},      32'(instr_pc),  32'(e.pc));
    end
  endtask

  task automatic finish_handshake(input string tag);
    @(negedge clk);
    ack_en = 1'b0;
    chk({tag, "_valid_drop"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic redirect(input logic [15:0] addr);
    redirect_en   = 1'b1;
    redirect_addr = addr;
    @(negedge clk);
    redirect_en   = 1'b0;
  endtask

  // Memory responder acts just after each falling edge so control changes made
  // by the main sequence at that edge are already visible.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (ack_always) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
      end else if (ack_en && mem_rd === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wait_cnt  = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wait_cnt  = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    rst_n         = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = 16'h0000;
    instr_ready   = 1'b1;
    ack_en        = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_rd",   32'(mem_rd),      32'd0);
    chk("rst_valid",    32'(instr_valid), 32'd0);
    chk("rst_illegal",  32'(illegal_op),  32'd0);
    chk("rst_opcode",   32'(opcode),      32'd0);
    chk("rst_operand",  32'(operand),     32'd0);
    chk("rst_len",      32'(instr_len),   32'd0);
    chk("rst_instr_pc", 32'(instr_pc),    32'd0);
    chk("rst_mem_addr", 32'(mem_addr),    32'h0000);

    // A9 42 straight out of reset: valid in the third cycle
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h42;
    push(8'hA9, 16'h0042, 2'd2, 16'h0000);
    rst_n = 1'b1;
    expect_instr("t1", lat);
    chk("t1_latency", 32'(lat), 32'd3);
    finish_handshake("t1");
    chk("t1_next_addr", 32'(mem_addr), 32'h0002);
    chk("t1_next_rd",   32'(mem_rd),   32'd1);

    // 4C 34 12 held under back-pressure; stray acks while not reading are ignored
    mem[16'h0010] = 8'h4C; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    instr_ready = 1'b0;
    redirect(16'h0010);
    ack_en = 1'b1;
    push(8'h4C, 16'h1234, 2'd3, 16'h0010);
    expect_instr("t2", lat);
    ack_always = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid",   32'(instr_valid), 32'd1);
      chk("t2_hold_opcode",  32'(opcode),      32'h4C);
      chk("t2_hold_operand", 32'(operand),     32'h1234);
      chk("t2_hold_len",     32'(instr_len),   32'd3);
      chk("t2_hold_rd",      32'(mem_rd),      32'd0);
      chk("t2_hold_addr",    32'(mem_addr),    32'h0013);
      @(negedge clk);
    end
    ack_always  = 1'b0;
    instr_ready = 1'b1;
    finish_handshake("t2");
    chk("t2_next_addr", 32'(mem_addr), 32'h0013);

    // 8D 00 20 with three wait cycles per byte
    mem[16'h0000] = 8'h8D; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h20;
    redirect(16'h0000);
    ack_delay = 3;
    ack_en    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("t3_wait_addr", 32'(mem_addr), 32'(k));
        chk("t3_wait_rd",   32'(mem_rd),   32'd1);
        @(negedge clk);
      end
    end
    push(8'h8D, 16'h2000, 2'd3, 16'h0000);
    expect_instr("t3", lat);
    finish_handshake("t3");
    chk("t3_pc_after", 32'(mem_addr), 32'h0003);
    ack_delay = 0;

    // Redirect to 1000 during FETCH_LO with a coincident ack
    mem[16'h0030] = 8'hA9; mem[16'h0031] = 8'h55;
    mem[16'h1000] = 8'h01; mem[16'h1001] = 8'h77;
    redirect(16'h0030);
    ack_en = 1'b1;
    @(negedge clk);
    chk("t4_in_lo_addr", 32'(mem_addr), 32'h0031);
    redirect(16'h1000);
    chk("t4_redir_addr",  32'(mem_addr),    32'h1000);
    chk("t4_redir_valid", 32'(instr_valid), 32'd0);
    push(8'h01, 16'h0077, 2'd2, 16'h1000);
    expect_instr("t4", lat);
    finish_handshake("t4");
    chk("t4_next_addr", 32'(mem_addr), 32'h1002);

    // 3-byte opcode at FFFF wraps its operand fetches to 0000/0001
    mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'hCD; mem[16'h0001] = 8'hAB;
    redirect(16'hFFFF);
    ack_en = 1'b1;
    push(8'h4C, 16'hABCD, 2'd3, 16'hFFFF);
    expect_instr("t5", lat);
    finish_handshake("t5");
    chk("t5_pc_wrap", 32'(mem_addr), 32'h0002);

    // Unknown opcode FF
    mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'hA9; mem[16'h0042] = 8'h11;
    redirect(16'h0040);
    ack_en = 1'b1;
    push(8'hFF, 16'h0000, 2'd1, 16'h0040);
    expect_instr("t6", lat);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    chk("t6_illegal_set", 32'(illegal_op), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_halt_rd",      32'(mem_rd),      32'd0);
      chk("t6_halt_valid",   32'(instr_valid), 32'd0);
      chk("t6_halt_illegal", 32'(illegal_op),  32'd1);
    end
    mem[16'h0100] = 8'hA9; mem[16'h0101] = 8'h66;
    redirect(16'h0100);
    chk("t6_resume_illegal", 32'(illegal_op), 32'd0);
    chk("t6_resume_addr",    32'(mem_addr),   32'h0100);
    chk("t6_resume_rd",      32'(mem_rd),     32'd1);
    push(8'hA9, 16'h0066, 2'd2, 16'h0100);
    expect_instr("t6r", lat);
    finish_handshake("t6r");
`else
    chk("t6_illegal_clear", 32'(illegal_op), 32'd0);
    @(negedge clk);
    chk("t6_continue_addr", 32'(mem_addr), 32'h0041);
    push(8'hA9, 16'h0011, 2'd2, 16'h0041);
    expect_instr("t6n", lat);
    finish_handshake("t6n");
`endif

    // Reset in the middle of a slow fetch
    mem[16'h0050] = 8'h8D; mem[16'h0051] = 8'h11; mem[16'h0052] = 8'h22;
    ack_delay = 3;
    redirect(16'h0050);
    ack_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t7_pre_rd", 32'(mem_rd), 32'd1);
    rst_n  = 1'b0;
    ack_en = 1'b0;
    #1;
    chk("t7_async_rd",      32'(mem_rd),      32'd0);
    chk("t7_async_valid",   32'(instr_valid), 32'd0);
    chk("t7_async_opcode",  32'(opcode),      32'd0);
    chk("t7_async_operand", 32'(operand),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t7_post_valid", 32'(instr_valid), 32'd0);
      chk("t7_post_addr",  32'(mem_addr),    32'h0000);
    end
    chk("t7_post_rd", 32'(mem_rd), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
